// File: rtl/intc_pkg.sv
// Shared register map and constants for the memory-mapped interrupt controller.
package intc_pkg;

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_TRIGGER = 3'd2,
    REG_ID      = 3'd3,
    REG_CTRL    = 3'd4
  } intc_reg_e;

  localparam logic [31:0] ID_NONE  = 32'h8000_0000;
  localparam int          CTRL_GIE = 0;
  localparam int          NUM_REGS = 8;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-set-bit encoder: lower index has priority.
module intc_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [4:0]         idx
);

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches device requests into pending
// bits, masks them, and raises a registered hwint for the CPU control unit.
module int_ctrl
  import intc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_fff0,
  parameter int          NUM_IRQ   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  input  logic               mem_rd,
  input  logic               mem_wr,
  output logic               sel,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               hwint
);

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] trigger_q, trigger_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic               gie_q, gie_d;
  logic               hwint_q, hwint_d;

  logic [31:0]        offset;
  logic [2:0]         reg_off;
  logic               wr_en;
  logic               rd_en;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic               id_valid;
  logic [4:0]         id_idx;
  logic [31:0]        rdata;
  logic               unused_din;

  // Unsigned subtract makes addresses below the base wrap to a large value,
  // so a single compare covers both window edges.
  assign offset  = addr - BASE_ADDR;
  assign sel     = (offset < 32'(NUM_REGS));
  assign reg_off = offset[2:0];
  assign wr_en   = mem_wr & sel;
  assign rd_en   = mem_rd & sel;

  // Only the low NUM_IRQ bits of write data carry register content.
  assign unused_din = ^din;

  intc_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (pending_q & enable_q),
    .valid (id_valid),
    .idx   (id_idx)
  );

  // Next-state for the register file: sources set, software clears, set wins.
  always_comb begin
    set_vec   = (trigger_q & irq & ~irq_q) | (~trigger_q & irq);
    clr_vec   = '0;
    enable_d  = enable_q;
    trigger_d = trigger_q;
    gie_d     = gie_q;
    if (wr_en) begin
      case (reg_off)
        REG_PENDING: clr_vec   = din[NUM_IRQ-1:0];
        REG_ENABLE:  enable_d  = din[NUM_IRQ-1:0];
        REG_TRIGGER: trigger_d = din[NUM_IRQ-1:0];
        REG_ID: begin
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (din[4:0] == 5'(i)) clr_vec[i] = 1'b1;
          end
        end
        REG_CTRL:    gie_d     = din[CTRL_GIE];
        default:     ;
      endcase
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
    hwint_d   = gie_q & (|(pending_q & enable_q));
  end

  // State registers; sampling irq into irq_q during reset suppresses a false
  // edge from a line that is already high when reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
      trigger_q <= '0;
      gie_q     <= 1'b0;
      hwint_q   <= 1'b0;
      irq_q     <= irq;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      gie_q     <= gie_d;
      hwint_q   <= hwint_d;
      irq_q     <= irq;
    end
  end

  // Combinational read mux; zero when not addressed so it can be OR-ed onto the bus.
  always_comb begin
    rdata = '0;
    case (reg_off)
      REG_PENDING: rdata = 32'(pending_q);
      REG_ENABLE:  rdata = 32'(enable_q);
      REG_TRIGGER: rdata = 32'(trigger_q);
      REG_ID:      rdata = id_valid ? {27'd0, id_idx} : ID_NONE;
      REG_CTRL:    rdata = {31'd0, gie_q};
      default:     rdata = '0;
    endcase
    dout = rd_en ? rdata : '0;
  end

  assign hwint = hwint_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios followed by random bus/irq traffic,
// all compared against a behavioural register-map model.
module tb_int_ctrl;

  localparam logic [31:0] BASE = 32'h0000_fff0;
  localparam int          NIRQ = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din, dout;
  logic        mem_rd, mem_wr, sel, hwint;
  logic [7:0]  irq;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  bit [7:0] m_pend, m_en, m_trig, m_prev;
  bit       m_gie, m_hwint;

  int_ctrl #(.BASE_ADDR(BASE), .NUM_IRQ(NIRQ)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .sel(sel), .irq(irq), .hwint(hwint)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    case (off)
      0: return {24'd0, m_pend};
      1: return {24'd0, m_en};
      2: return {24'd0, m_trig};
      3: begin
        for (int n = 0; n < NIRQ; n++)
          if (m_pend[n] && m_en[n]) return n;
        return 32'h8000_0000;
      end
      4: return {31'd0, m_gie};
      default: return 0;
    endcase
  endfunction

  // One bus cycle: drive, check combinational outputs, clock, update model, check hwint.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic rd, input logic wr, input logic [7:0] iv);
    bit        in_win;
    bit [7:0]  nxt;
    bit        any;
    bit        new_hw;
    logic [31:0] off;
    rst = r; addr = a; din = d; mem_rd = rd; mem_wr = wr; irq = iv;
    #1;
    in_win = (a >= BASE) && (a <= BASE + 7);
    chk("sel", {31'd0, sel}, {31'd0, in_win});
    chk("dout", dout, (rd && in_win) ? m_read(a) : 32'd0);
    @(posedge clk);
    if (r) begin
      m_pend = 0; m_en = 0; m_trig = 0; m_gie = 0; m_hwint = 0;
    end else begin
      any = 0;
      for (int n = 0; n < NIRQ; n++) any |= m_pend[n] & m_en[n];
      new_hw = m_gie & any;
      nxt = m_pend;
      off = a - BASE;
      if (wr && in_win) begin
        case (off)
          0: nxt = m_pend & ~d[7:0];
          1: m_en = d[7:0];
          3: if (d[4:0] < NIRQ) nxt[d[4:0]] = 1'b0;
          4: m_gie = d[0];
          default: ;
        endcase
      end
      for (int n = 0; n < NIRQ; n++) begin
        if (m_trig[n] ? (iv[n] && !m_prev[n]) : iv[n]) nxt[n] = 1'b1;
      end
      if (wr && in_win && off == 2) m_trig = d[7:0];
      m_pend  = nxt;
      m_hwint = new_hw;
    end
    m_prev = iv;
    #1;
    chk("hwint", {31'd0, hwint}, {31'd0, m_hwint});
  endtask

  task automatic wr_reg(input int off, input logic [31:0] d, input logic [7:0] iv);
    step(1'b0, BASE + off, d, 1'b0, 1'b1, iv);
  endtask

  task automatic rd_reg(input int off, input logic [7:0] iv);
    step(1'b0, BASE + off, 32'd0, 1'b1, 1'b0, iv);
  endtask

  initial begin
    logic [31:0] a, d;
    int          off;
    // Test 1: reset with irq[0] already high
    rst = 1'b1; addr = 0; din = 0; mem_rd = 0; mem_wr = 0; irq = 8'h01;
    @(posedge clk); #1;
    m_pend = 0; m_en = 0; m_trig = 0; m_gie = 0; m_hwint = 0; m_prev = irq;
    step(1'b1, BASE, 32'hff, 1'b1, 1'b1, 8'h01);
    chk("reset_pending", {24'd0, dut.pending_q}, 32'd0);
    wr_reg(2, 32'hff, 8'h01);
    wr_reg(0, 32'hff, 8'h01);
    wr_reg(1, 32'h05, 8'h01);
    wr_reg(4, 32'h1, 8'h01);
    rd_reg(0, 8'h01);
    wr_reg(1, 32'h00, 8'h01);
    for (int i = 0; i < 10; i++) rd_reg(0, 8'h01);
    // Test 2: edge pulse on irq[2], identify and acknowledge
    wr_reg(1, 32'h05, 8'h00);
    step(1'b0, BASE, 0, 1'b0, 1'b0, 8'h04);
    rd_reg(0, 8'h00);
    rd_reg(3, 8'h00);
    wr_reg(3, 32'd2, 8'h00);
    rd_reg(0, 8'h00);
    rd_reg(0, 8'h00);
    // Test 3: level mode on irq[0]
    wr_reg(2, 32'hfe, 8'h01);
    rd_reg(0, 8'h01);
    wr_reg(0, 32'h01, 8'h01);
    rd_reg(0, 8'h01);
    rd_reg(0, 8'h00);
    wr_reg(0, 32'h01, 8'h00);
    rd_reg(0, 8'h00);
    rd_reg(0, 8'h00);
    // Test 4: edge on irq[3] in the same cycle as its W1C
    wr_reg(0, 32'h08, 8'h08);
    rd_reg(0, 8'h00);
    chk("set_wins", {24'd0, dut.pending_q & 8'h08}, 32'h8);
    wr_reg(0, 32'hff, 8'h00);
    // Test 5: priority and masking
    step(1'b0, BASE, 0, 1'b0, 1'b0, 8'h06);
    wr_reg(1, 32'h04, 8'h00);
    rd_reg(3, 8'h00);
    wr_reg(1, 32'h00, 8'h00);
    rd_reg(3, 8'h00);
    rd_reg(3, 8'h00);
    wr_reg(1, 32'h06, 8'h00);
    wr_reg(4, 32'h0, 8'h00);
    rd_reg(3, 8'h00);
    rd_reg(4, 8'h00);
    // Test 6: unused offsets, high bits, outside window
    for (int o = 5; o < 8; o++) begin
      wr_reg(o, 32'hffff_ffff, 8'h00);
      rd_reg(o, 8'h00);
    end
    wr_reg(1, 32'hffff_ff00, 8'h00);
    rd_reg(1, 8'h00);
    step(1'b0, BASE - 1, 32'hff, 1'b1, 1'b1, 8'h00);
    step(1'b0, BASE + 8, 32'hff, 1'b1, 1'b1, 8'h00);
    step(1'b0, 32'h0000_0003, 32'hff, 1'b1, 1'b0, 8'h00);
    // Simultaneous read and write returns old value
    step(1'b0, BASE + 1, 32'h3c, 1'b1, 1'b1, 8'h00);
    rd_reg(1, 8'h00);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      off = $urandom_range(0, 9);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = BASE + off;
      d = $urandom;
      if (off == 3 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 31);
      step(($urandom_range(0, 60) == 0), a, d, 1'($urandom), 1'($urandom_range(0, 2) == 0),
           8'($urandom & $urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
